// File: rtl/ling_digit_serial_addsub.sv
// ling_digit_serial_addsub: multi-cycle add/subtract, one DIGIT-bit Ling group per clock
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   operand handshake; a, b, cin, sub sampled on accept
//   out_valid/out_ready result handshake; sum, cout, ovf held while out_valid
//   sub=0: a+b+cin; sub=1: a-b-cin (cout=1 means no borrow); ovf is signed overflow
module ling_digit_serial_addsub #(
  parameter int WIDTH = 64,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] ra, rb;
  logic c, dco, last;
  logic [CW-1:0] cnt;
  logic [DIGIT-1:0] p, g, t, cc, ds;
  logic [DIGIT:1] h;
  assign p = ra[DIGIT-1:0] ^ rb[DIGIT-1:0];
  assign g = ra[DIGIT-1:0] & rb[DIGIT-1:0];
  assign t = ra[DIGIT-1:0] | rb[DIGIT-1:0];
  // Ling pseudo-carries h, then true carries cc = t(i-1) & h(i)
  always_comb begin
    h = '0;
    cc = '0;
    h[1] = g[0] | c;
    cc[0] = c;
    for (int i = 1; i < DIGIT; i++) begin
      cc[i] = t[i-1] & h[i];
      h[i+1] = g[i] | cc[i];
    end
    dco = t[DIGIT-1] & h[DIGIT];
    ds = p ^ cc;
  end
  assign last = cnt == CW'(N - 1);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    nxt = state;
    if (state == IDLE && in_valid) nxt = RUN;
    else if (state == RUN && last) nxt = DONE;
    else if (state == DONE && out_ready) nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // operands shift right so the active digit is always in the low bits
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ra <= '0;
      rb <= '0;
      c <= 1'b0;
      cnt <= '0;
      sum <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      ra <= a;
      rb <= b ^ {WIDTH{sub}};
      c <= cin ^ sub;
      cnt <= '0;
    end else if (state == RUN) begin
      ra <= ra >> DIGIT;
      rb <= rb >> DIGIT;
      c <= dco;
      cnt <= cnt + 1'b1;
      sum <= {ds, sum[WIDTH-1:DIGIT]};
      if (last) begin
        cout <= dco;
        ovf <= cc[DIGIT-1] ^ dco;
      end
    end
endmodule

// File: tb/tb_ling_digit_serial_addsub.sv
// tb_ling_digit_serial_addsub: directed vector bench for the digit-serial Ling adder/subtractor
module tb_ling_digit_serial_addsub;
  logic clk = 0, rst_n = 0, in_valid = 0, in_ready, cin = 0, sub = 0;
  logic out_valid, out_ready = 0, cout, ovf;
  logic [63:0] a = '0, b = '0, sum;
  int errs = 0, total = 0;
  typedef struct {
    string nm;
    logic [63:0] a, b;
    logic cin, sub;
    logic [63:0] s;
    logic co, ov;
  } vec_t;
  vec_t v[7];
  ling_digit_serial_addsub dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic wait_done(input string nm, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 40);
    chk({nm, " latency"}, 64'(n), 64'd16);
  endtask
  task automatic do_op(input vec_t r);
    int n;
    a = r.a;
    b = r.b;
    cin = r.cin;
    sub = r.sub;
    in_valid = 1;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({r.nm, " ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 0;
    a = '0;
    b = '0;
    chk({r.nm, " busy"}, 64'(in_ready), 64'd0);
    wait_done(r.nm, n);
    chk({r.nm, " sum"}, sum, r.s);
    chk({r.nm, " cout"}, 64'(cout), 64'(r.co));
    chk({r.nm, " ovf"}, 64'(ovf), 64'(r.ov));
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
    chk({r.nm, " idle"}, 64'({in_ready, out_valid}), 64'b10);
  endtask
  initial begin
    int n;
    v[0] = '{"add", 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 0, 0, 64'hFFFFFFFFFFFFFFFF, 0, 0};
    v[1] = '{"add_cin", 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 1, 0, 64'h0, 1, 0};
    v[2] = '{"sub_min", 64'h8000000000000000, 64'h1, 0, 1, 64'h7FFFFFFFFFFFFFFF, 1, 1};
    v[3] = '{"sub_bin", 64'h5, 64'h3, 1, 1, 64'h1, 1, 0};
    v[4] = '{"add_max", 64'h7FFFFFFFFFFFFFFF, 64'h1, 0, 0, 64'h8000000000000000, 0, 1};
    v[5] = '{"sub_borrow", 64'h0, 64'h1, 0, 1, 64'hFFFFFFFFFFFFFFFF, 0, 0};
    v[6] = '{"add_small", 64'h5, 64'h3, 0, 0, 64'h8, 0, 0};
    #12;
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst sum", sum, 64'd0);
    chk("rst cout_ovf", 64'({cout, ovf}), 64'd0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    foreach (v[i]) do_op(v[i]);
    // backpressure: first op waits in DONE while the second is held on the input
    a = v[6].a;
    b = v[6].b;
    cin = 0;
    sub = 0;
    in_valid = 1;
    @(posedge clk);
    #1;
    a = v[4].a;
    b = v[4].b;
    wait_done("bp1", n);
    for (int i = 0; i < 5; i++) begin
      chk("bp hold valid", 64'(out_valid), 64'd1);
      chk("bp hold ready", 64'(in_ready), 64'd0);
      chk("bp hold sum", sum, 64'h8);
      chk("bp hold flags", 64'({cout, ovf}), 64'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
    chk("bp idle", 64'({in_ready, out_valid}), 64'b10);
    @(posedge clk);
    #1;
    in_valid = 0;
    chk("bp accept2", 64'(in_ready), 64'd0);
    wait_done("bp2", n);
    chk("bp2 sum", sum, v[4].s);
    chk("bp2 flags", 64'({cout, ovf}), 64'b01);
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
    // reset while processing digit 7
    a = v[0].a;
    b = v[0].b;
    in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    chk("rst mid out_valid", 64'(out_valid), 64'd0);
    chk("rst mid in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    do_op(v[0]);
    $display("Result: errors=%0d of %0d checks", errs, total);
    $finish;
  end
endmodule
